branch_resolver: RTL and testbench

Tracks every fetch-stage branch prediction through the pipeline and checks it against the real outcome computed in EX. On a mismatch it sends a one-cycle flush and redirect PC to the front end. It also drives the training port of the branch predictor: `opt_is_jmp`, `pc_ex`, `ifjmp_target` and `jmp_res`. The block sits between IF (producer of prediction records) and EX (consumer), and closes the predictor's update loop.

---
 rtl/branch_resolver_pkg.sv | 43 ++++
 rtl/branch_resolver_fifo.sv | 74 +++++++
 rtl/branch_resolver.sv | 135 +++++++++++++
 tb/tb_branch_resolver.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolver_pkg
//   Shared definitions for the branch resolution slice:
//     INST_ADDR_BUS  instruction address width used by the front end
//     record_bus()   width of one prediction record {pc, pre_taken, pre_target}
//     RECORD_BUS     record width at the default address width (also used by IF)
//     res_kind_e     outcome of comparing a prediction with the EX result
//     classify()     maps prediction + outcome onto res_kind_e
// -----------------------------------------------------------------------------
package branch_resolver_pkg;

   localparam int INST_ADDR_BUS = 32;

   function automatic int record_bus(input int addr_w);
      return 2 * addr_w + 1;
   endfunction

   localparam int RECORD_BUS = record_bus(INST_ADDR_BUS);

   typedef enum logic [1:0] {
      RES_NONE       = 2'd0,  // non-jump, predicted not-taken: nothing to do
      RES_JMP_OK     = 2'd1,  // jump, prediction correct: train only
      RES_JMP_MISS   = 2'd2,  // jump, prediction wrong: train and flush
      RES_ALIAS_MISS = 2'd3   // non-jump predicted taken (BTB tag alias): flush only
   } res_kind_e;

   // target_eq is only meaningful when the jump was actually taken; a
   // not-taken jump with a correct not-taken prediction ignores targets.
   function automatic res_kind_e classify(input logic is_jmp,
                                          input logic pre_taken,
                                          input logic taken,
                                          input logic target_eq);
      if (is_jmp) begin
         if ((pre_taken != taken) || (taken && !target_eq))
            return RES_JMP_MISS;
         return RES_JMP_OK;
      end
      if (pre_taken)
         return RES_ALIAS_MISS;
      return RES_NONE;
   endfunction

endpackage

// File: rtl/branch_resolver_fifo.sv
// -----------------------------------------------------------------------------
// bp_record_fifo
//   Circular FIFO holding in-flight prediction records.
//   Ports:
//     clk, rst     clock, asynchronous active-low reset
//     en           global enable; state frozen while low
//     clr          synchronous clear of pointers and count (wins over push/pop)
//     push, din    write one record (caller guarantees space or a same-cycle pop)
//     pop, dout    retire the head record (caller guarantees non-empty)
//     full, empty  occupancy flags, combinational from the registered count
// -----------------------------------------------------------------------------
module bp_record_fifo
   import branch_resolver_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = RECORD_BUS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   // NOTE: sequential state is updated only with non-blocking assignments so
   // every register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (en) begin
         if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end
   end

   // NOTE: the storage array has no reset; validity is tracked by the pointers
   // and count, so clearing it would only cost a reset tree on every bit.
   always_ff @(posedge clk) begin
      if (en && push && !clr)
         mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
//   Checks each fetch-stage branch prediction against the EX outcome, issues a
//   one-cycle flush + redirect on a mispredict and trains the predictor.
//   Ports:
//     clk, rst                 clock, asynchronous active-low reset
//     rdy                      global enable (freezes everything when low)
//     if_valid/if_pc/if_pre_*  prediction record pushed by IF; full = IF stall
//     ex_valid/ex_*            EX completion; pops and resolves the head record
//     upd_*                    predictor training port, one-cycle pulse
//     flush, redirect_pc       one-cycle front-end flush and restart PC
//     br_cnt, miss_cnt         resolved jumps / flushes issued (wrap at 2^32)
//     err                      sticky protocol error
// -----------------------------------------------------------------------------
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = INST_ADDR_BUS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              if_valid,
   input  logic [ADDR_W-1:0] if_pc,
   input  logic              if_pre_taken,
   input  logic [ADDR_W-1:0] if_pre_target,
   output logic              full,
   input  logic              ex_valid,
   input  logic [ADDR_W-1:0] ex_pc,
   input  logic              ex_is_jmp,
   input  logic              ex_taken,
   input  logic [ADDR_W-1:0] ex_target,
   output logic              upd_valid,
   output logic [ADDR_W-1:0] upd_pc,
   output logic [ADDR_W-1:0] upd_target,
   output logic              upd_taken,
   output logic              flush,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic [31:0]       br_cnt,
   output logic [31:0]       miss_cnt,
   output logic              err
);

   localparam int REC_W = record_bus(ADDR_W);

   logic              push_req;
   logic              pop_req;
   logic              push;
   logic              pop;
   logic              fifo_empty;
   logic [REC_W-1:0]  head;
   logic [ADDR_W-1:0] head_pc;
   logic              head_pre_taken;
   logic [ADDR_W-1:0] head_pre_target;
   res_kind_e         kind;
   logic              mispredict;
   logic              train;
   logic              err_set;
   logic [ADDR_W-1:0] redirect_nxt;

   // The cycle in which flush is high is a drain cycle: both sides are ignored.
   assign push_req = if_valid & ~flush;
   assign pop_req  = ex_valid & ~flush;

   // No bypass: an empty queue cannot be popped even if IF pushes this cycle.
   assign pop  = pop_req & ~fifo_empty;
   assign push = push_req & (~full | pop);

   // Record layout: {pc, pre_taken, pre_target}.
   assign head_pc         = head[REC_W-1 -: ADDR_W];
   assign head_pre_taken  = head[ADDR_W];
   assign head_pre_target = head[ADDR_W-1:0];

   // NOTE: every signal written in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      kind = RES_NONE;
      if (pop)
         kind = classify(ex_is_jmp, head_pre_taken, ex_taken,
                         head_pre_target == ex_target);
   end

   assign mispredict   = (kind == RES_JMP_MISS) || (kind == RES_ALIAS_MISS);
   assign train        = (kind == RES_JMP_OK)   || (kind == RES_JMP_MISS);
   assign redirect_nxt = ex_taken ? ex_target : ex_pc + ADDR_W'(4);

   assign err_set = (push_req & full & ~pop)         // overflow, record dropped
                  | (pop_req & fifo_empty)           // EX completion with no record
                  | (pop & (ex_pc != head_pc));      // record out of step with EX

   // A mispredict clears the queue on the same edge; records still queued and
   // any push this cycle belong to the wrong path.
   bp_record_fifo #(
      .DEPTH (DEPTH),
      .W     (REC_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .en    (rdy),
      .clr   (mispredict),
      .push  (push),
      .din   ({if_pc, if_pre_taken, if_pre_target}),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         upd_valid   <= 1'b0;
         upd_pc      <= '0;
         upd_target  <= '0;
         upd_taken   <= 1'b0;
         flush       <= 1'b0;
         redirect_pc <= '0;
         br_cnt      <= '0;
         miss_cnt    <= '0;
         err         <= 1'b0;
      end else if (rdy) begin
         // Address outputs read as zero outside their pulse.
         upd_valid   <= train;
         upd_pc      <= train ? ex_pc : '0;
         upd_target  <= train ? ex_target : '0;
         upd_taken   <= train & ex_taken;
         flush       <= mispredict;
         redirect_pc <= mispredict ? redirect_nxt : '0;
         if (train)      br_cnt   <= br_cnt + 32'd1;
         if (mispredict) miss_cnt <= miss_cnt + 32'd1;
         if (err_set)    err      <= 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        if_pre_taken;
   logic [31:0] if_pre_target;
   logic        full;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_is_jmp;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [31:0] br_cnt;
   logic [31:0] miss_cnt;
   logic        err;

   int total = 0;
   int bad   = 0;

   branch_resolver #(.DEPTH(4), .ADDR_W(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_pre_taken  (if_pre_taken),
      .if_pre_target (if_pre_target),
      .full          (full),
      .ex_valid      (ex_valid),
      .ex_pc         (ex_pc),
      .ex_is_jmp     (ex_is_jmp),
      .ex_taken      (ex_taken),
      .ex_target     (ex_target),
      .upd_valid     (upd_valid),
      .upd_pc        (upd_pc),
      .upd_target    (upd_target),
      .upd_taken     (upd_taken),
      .flush         (flush),
      .redirect_pc   (redirect_pc),
      .br_cnt        (br_cnt),
      .miss_cnt      (miss_cnt),
      .err           (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;  logic [31:0] ipc; logic ipt; logic [31:0] itg;
      logic        ev;  logic [31:0] epc; logic ej;  logic et;  logic [31:0] etg;
      logic        xfull; logic xuv; logic [31:0] xupc; logic [31:0] xutg; logic xut;
      logic        xfl; logic [31:0] xrd; logic [31:0] xbr; logic [31:0] xms; logic xerr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic iv, input logic [31:0] ipc, input logic ipt, input logic [31:0] itg,
      input logic ev, input logic [31:0] epc, input logic ej, input logic et, input logic [31:0] etg,
      input logic xfull, input logic xuv, input logic [31:0] xupc, input logic [31:0] xutg,
      input logic xut, input logic xfl, input logic [31:0] xrd,
      input logic [31:0] xbr, input logic [31:0] xms, input logic xerr);
      vec_t v;
      v.iv = iv; v.ipc = ipc; v.ipt = ipt; v.itg = itg;
      v.ev = ev; v.epc = epc; v.ej = ej; v.et = et; v.etg = etg;
      v.xfull = xfull; v.xuv = xuv; v.xupc = xupc; v.xutg = xutg; v.xut = xut;
      v.xfl = xfl; v.xrd = xrd; v.xbr = xbr; v.xms = xms; v.xerr = xerr;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [31:0] ipc, input logic ipt,
                        input logic [31:0] itg, input logic ev, input logic [31:0] epc,
                        input logic ej, input logic et, input logic [31:0] etg);
      if_valid = iv; if_pc = ipc; if_pre_taken = ipt; if_pre_target = itg;
      ex_valid = ev; ex_pc = epc; ex_is_jmp = ej; ex_taken = et; ex_target = etg;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".upd_valid"},   32'(upd_valid),  0);
      check({tag, ".upd_pc"},      upd_pc,          0);
      check({tag, ".upd_target"},  upd_target,      0);
      check({tag, ".upd_taken"},   32'(upd_taken),  0);
      check({tag, ".flush"},       32'(flush),      0);
      check({tag, ".redirect_pc"}, redirect_pc,     0);
      check({tag, ".br_cnt"},      br_cnt,          0);
      check({tag, ".miss_cnt"},    miss_cnt,        0);
      check({tag, ".err"},         32'(err),        0);
      check({tag, ".full"},        32'(full),       0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---------------- table of directed vectors ----------------
      vecs.push_back(mk(1,'h100,1,'h200, 0,0,0,0,0,          0,0,0,0,0,0,0,            0,0,0));
      vecs.push_back(mk(0,0,0,0, 1,'h100,1,1,'h200,          0,1,'h100,'h200,1,0,0,    1,0,0));
      vecs.push_back(mk(1,'h104,0,0, 0,0,0,0,0,              0,0,0,0,0,0,0,            1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,'h104,1,1,'h300,          0,1,'h104,'h300,1,1,'h300, 2,1,0));
      // flush cycle: both sides ignored (no err from empty pop, nothing queued)
      vecs.push_back(mk(1,'h500,0,0, 1,'h500,1,1,'h500,      0,0,0,0,0,0,0,            2,1,0));
      vecs.push_back(mk(1,'h108,1,'h400, 0,0,0,0,0,          0,0,0,0,0,0,0,            2,1,0));
      vecs.push_back(mk(0,0,0,0, 1,'h108,0,0,0,              0,0,0,0,0,1,'h10C,        2,2,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,                  0,0,0,0,0,0,0,            2,2,0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(1, 32'h200 + 32'(4*i), 1, 32'h1200 + 32'(4*i), 0,0,0,0,0,
                           (i == 3), 0,0,0,0,0,0, 2,2,0));
      // fifth push while full: dropped, err set, still full
      vecs.push_back(mk(1,'h210,1,'h1210, 0,0,0,0,0,         1,0,0,0,0,0,0,            2,2,1));
      // push+pop at full, eight records through the wrapping pointers
      for (int k = 0; k < 8; k++)
         vecs.push_back(mk(1, 32'h210 + 32'(4*k), 1, 32'h1210 + 32'(4*k),
                           1, 32'h200 + 32'(4*k), 1, 1, 32'h1200 + 32'(4*k),
                           1, 1, 32'h200 + 32'(4*k), 32'h1200 + 32'(4*k), 1, 0, 0,
                           32'(3 + k), 2, 1));
      // mispredict with 3 younger records plus a same-cycle push: queue cleared
      vecs.push_back(mk(1,'h230,1,'h1230, 1,'h220,1,1,'h9999, 0,1,'h220,'h9999,1,1,'h9999, 11,3,1));
      // flush cycle inputs ignored; a queued 0x300 would mispredict the next pop
      vecs.push_back(mk(1,'h300,1,'h777, 1,'h224,1,1,'h1224, 0,0,0,0,0,0,0,            11,3,1));
      vecs.push_back(mk(1,'h304,0,0, 0,0,0,0,0,              0,0,0,0,0,0,0,            11,3,1));
      vecs.push_back(mk(0,0,0,0, 1,'h304,1,0,0,              0,1,'h304,0,0,0,0,        12,3,1));
      // redirect wraps modulo 2^32
      vecs.push_back(mk(1,'hFFFFFFFC,1,0, 0,0,0,0,0,         0,0,0,0,0,0,0,            12,3,1));
      vecs.push_back(mk(0,0,0,0, 1,'hFFFFFFFC,0,0,0,         0,0,0,0,0,1,0,            12,4,1));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,                  0,0,0,0,0,0,0,            12,4,1));

      // ---------------- reset ----------------
      rst = 1'b0;
      rdy = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      check_all_zero("reset");

      // ---------------- table-driven run ----------------
      foreach (vecs[i]) begin
         vec_t v;
         string t;
         v = vecs[i];
         t = $sformatf("v%0d", i);
         drive(v.iv, v.ipc, v.ipt, v.itg, v.ev, v.epc, v.ej, v.et, v.etg);
         step();
         check({t, ".full"},        32'(full),      32'(v.xfull));
         check({t, ".upd_valid"},   32'(upd_valid), 32'(v.xuv));
         check({t, ".upd_pc"},      upd_pc,         v.xupc);
         check({t, ".upd_target"},  upd_target,     v.xutg);
         check({t, ".upd_taken"},   32'(upd_taken), 32'(v.xut));
         check({t, ".flush"},       32'(flush),     32'(v.xfl));
         check({t, ".redirect_pc"}, redirect_pc,    v.xrd);
         check({t, ".br_cnt"},      br_cnt,         v.xbr);
         check({t, ".miss_cnt"},    miss_cnt,       v.xms);
         check({t, ".err"},         32'(err),       32'(v.xerr));
      end

      // ---------------- rdy low holds a flush pulse ----------------
      drive(1, 'h400, 0, 0, 0, 0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 1, 'h400, 1, 1, 'h500);
      step();
      check("rdy.flush_pre", 32'(flush), 1);
      check("rdy.redir_pre", redirect_pc, 'h500);
      rdy = 1'b0;
      drive(1, 'h404, 1, 'h1, 1, 'h400, 1, 1, 'h600);
      repeat (3) step();
      check("rdy.flush_held", 32'(flush),     1);
      check("rdy.redir_held", redirect_pc,    'h500);
      check("rdy.upd_held",   32'(upd_valid), 1);
      check("rdy.miss_held",  miss_cnt,       5);
      check("rdy.br_held",    br_cnt,         13);
      rdy = 1'b1;
      idle();
      step();
      check("rdy.flush_end", 32'(flush),     0);
      check("rdy.redir_end", redirect_pc,    0);
      check("rdy.upd_end",   32'(upd_valid), 0);
      check("rdy.miss_end",  miss_cnt,       5);

      // ---------------- async reset during a flush ----------------
      drive(1, 'h600, 1, 0, 0, 0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 1, 'h600, 0, 0, 0);
      step();
      check("rstf.flush_pre", 32'(flush), 1);
      check("rstf.redir_pre", redirect_pc, 'h604);
      idle();
      #2 rst = 1'b0;
      #1;
      check_all_zero("rstf");
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, 0, 1, 'h700, 1, 1, 'h800);
      step();
      check("empty_pop.err",       32'(err),       1);
      check("empty_pop.flush",     32'(flush),     0);
      check("empty_pop.upd_valid", 32'(upd_valid), 0);
      check("empty_pop.br_cnt",    br_cnt,         0);

      // ---------------- pc mismatch: err set, pop proceeds ----------------
      idle();
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      drive(1, 'h800, 0, 0, 0, 0, 0, 0, 0);
      step();
      check("pcmis.err_pre", 32'(err), 0);
      drive(0, 0, 0, 0, 1, 'h804, 1, 0, 0);
      step();
      check("pcmis.err",       32'(err),       1);
      check("pcmis.upd_valid", 32'(upd_valid), 1);
      check("pcmis.upd_pc",    upd_pc,         'h804);
      check("pcmis.flush",     32'(flush),     0);
      check("pcmis.br_cnt",    br_cnt,         1);
      idle();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
